// File: rtl/usb_pkg.sv
// Shared USB receive-path definitions: read-size encodings, packet PID
// classes exchanged with usb_rx, and the read-size decode helper.
package usb_pkg;

  // rx_read_size encodings presented by the AHB slave
  localparam logic [1:0] RD_1B = 2'd0;
  localparam logic [1:0] RD_2B = 2'd1;
  localparam logic [1:0] RD_4B = 2'd2;

  // PID classes reported by usb_rx for the packet currently being received
  typedef enum logic [2:0] {
    RX_PID_NONE      = 3'd0,
    RX_PID_TOKEN     = 3'd1,
    RX_PID_DATA0     = 3'd2,
    RX_PID_DATA1     = 3'd3,
    RX_PID_HANDSHAKE = 3'd4,
    RX_PID_ERROR     = 3'd5
  } rx_pid_class_e;

  // Number of bytes moved by one read; the reserved code behaves as 4 bytes
  function automatic logic [2:0] read_size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      RD_1B:   n = 3'd1;
      RD_2B:   n = 3'd2;
      RD_4B:   n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port and four
// combinational read taps at consecutive addresses that wrap modulo DEPTH.
module usb_fifo_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [7:0]            wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [3:0][7:0]       rdata
);

  logic [7:0] mem_r [DEPTH];

  // Store the incoming byte; contents are not reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Four read taps; the ADDR_W-bit sum wraps naturally across the end of the array
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rdata[k] = mem_r[raddr + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Receive-side byte FIFO between usb_rx and the AHB slave. Bytes are stored
// one per cycle and drained in 1/2/4-byte little-endian reads. Occupancy,
// read data and the overflow/underflow pulses are all registered.
module usb_rx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              store_rx_packet,
  input  logic [7:0]        rx_packet_data,
  input  logic              get_rx_data,
  input  logic [1:0]        rx_read_size,
  input  logic              flush,
  output logic [31:0]       rx_data,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              rx_overflow,
  output logic              rx_underflow
);

  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   OCC_ZERO = {(ADDR_W + 1){1'b0}};

  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   occ_r;
  logic [31:0]       rx_data_r;
  logic              ovf_r;
  logic              udf_r;

  logic [2:0]        n_bytes_s;
  logic [ADDR_W:0]   rd_len_s;
  logic [ADDR_W:0]   occ_nxt_s;
  logic              rd_ok_s;
  logic              wr_ok_s;
  logic              ovf_s;
  logic              udf_s;
  logic [31:0]       rd_word_s;
  logic [3:0][7:0]   taps_s;

  usb_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok_s),
    .waddr (wr_ptr_r),
    .wdata (rx_packet_data),
    .raddr (rd_ptr_r),
    .rdata (taps_s)
  );

  // Decide read/write acceptance from the occupancy registered at the start of the cycle
  always_comb begin
    n_bytes_s = read_size_bytes(rx_read_size);
    rd_len_s  = (ADDR_W + 1)'(n_bytes_s);
    if (flush) begin
      rd_ok_s = 1'b0;
      wr_ok_s = 1'b0;
      udf_s   = 1'b0;
      ovf_s   = 1'b0;
    end else begin
      rd_ok_s = get_rx_data && (occ_r >= rd_len_s);
      // A full FIFO can still take a byte when a same-cycle read frees space
      wr_ok_s = store_rx_packet && ((occ_r < FULL_LVL) || rd_ok_s);
      udf_s   = get_rx_data && !rd_ok_s;
      ovf_s   = store_rx_packet && !wr_ok_s;
    end
    occ_nxt_s = occ_r + (ADDR_W + 1)'(wr_ok_s) - (rd_ok_s ? rd_len_s : OCC_ZERO);
  end

  // Assemble the little-endian read word, zeroing bytes beyond the read size
  always_comb begin
    case (n_bytes_s)
      3'd1:    rd_word_s = {24'h00_0000, taps_s[0]};
      3'd2:    rd_word_s = {16'h0000, taps_s[1], taps_s[0]};
      default: rd_word_s = {taps_s[3], taps_s[2], taps_s[1], taps_s[0]};
    endcase
  end

  // Pointer, occupancy, read-data and flag registers; flush clears them silently
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_r  <= {ADDR_W{1'b0}};
      wr_ptr_r  <= {ADDR_W{1'b0}};
      occ_r     <= OCC_ZERO;
      rx_data_r <= 32'h0000_0000;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else if (flush) begin
      rd_ptr_r  <= {ADDR_W{1'b0}};
      wr_ptr_r  <= {ADDR_W{1'b0}};
      occ_r     <= OCC_ZERO;
      rx_data_r <= 32'h0000_0000;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
    end else begin
      occ_r <= occ_nxt_s;
      ovf_r <= ovf_s;
      udf_r <= udf_s;
      if (rd_ok_s) begin
        rd_ptr_r  <= rd_ptr_r + ADDR_W'(n_bytes_s);
        rx_data_r <= rd_word_s;
      end
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  assign rx_data          = rx_data_r;
  assign buffer_occupancy = occ_r;
  assign rx_overflow      = ovf_r;
  assign rx_underflow     = udf_r;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Self-checking bench for usb_rx_data_buffer: a queue-based byte FIFO model
// is compared against the DUT on every falling edge, and directed scenarios
// pin both DUT and model to hand-computed values.
module tb_usb_rx_data_buffer;
  import usb_pkg::*;

  logic        tb_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        store_rx_packet = 1'b0;
  logic [7:0]  rx_packet_data = 8'h00;
  logic        get_rx_data = 1'b0;
  logic [1:0]  rx_read_size = 2'd0;
  logic        flush = 1'b0;
  logic [31:0] rx_data;
  logic [6:0]  buffer_occupancy;
  logic        rx_overflow;
  logic        rx_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  usb_rx_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk              (tb_clk),
    .n_rst            (n_rst),
    .store_rx_packet  (store_rx_packet),
    .rx_packet_data   (rx_packet_data),
    .get_rx_data      (get_rx_data),
    .rx_read_size     (rx_read_size),
    .flush            (flush),
    .rx_data          (rx_data),
    .buffer_occupancy (buffer_occupancy),
    .rx_overflow      (rx_overflow),
    .rx_underflow     (rx_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus the last read word and flag pulses
  byte unsigned q[$];
  logic [31:0]  m_data = 32'h0;
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;
  int           m_n;
  bit           m_rd, m_wr;
  logic [31:0]  m_w;

  initial begin
    forever begin
      @(posedge tb_clk or negedge n_rst);
      if (!n_rst || flush) begin
        q.delete();
        m_data = 32'h0; m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
        m_n  = (rx_read_size == RD_1B) ? 1 : (rx_read_size == RD_2B) ? 2 : 4;
        m_rd = get_rx_data && (q.size() >= m_n);
        m_wr = store_rx_packet && ((q.size() < 64) || m_rd);
        m_udf = get_rx_data && !m_rd;
        m_ovf = store_rx_packet && !m_wr;
        if (m_rd) begin
          m_w = 32'h0;
          for (int k = 0; k < m_n; k++) m_w[8*k +: 8] = q.pop_front();
          m_data = m_w;
        end
        if (m_wr) q.push_back(rx_packet_data);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge tb_clk) begin
    chk("rx_data", rx_data, m_data);
    chk("occupancy", 32'(buffer_occupancy), 32'(q.size()));
    chk("overflow", 32'(rx_overflow), 32'(m_ovf));
    chk("underflow", 32'(rx_underflow), 32'(m_udf));
  end

  // One clock of stimulus; returns 1 time unit after the edge that consumed it
  task automatic cyc(input logic st, input logic [7:0] d, input logic g,
                     input logic [1:0] sz, input logic fl);
    store_rx_packet = st; rx_packet_data = d; get_rx_data = g;
    rx_read_size = sz; flush = fl;
    @(posedge tb_clk); #1;
    store_rx_packet = 1'b0; get_rx_data = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [4];
    repeat (3) @(posedge tb_clk);
    #1;
    chk("rst_data", rx_data, 32'h0);
    chk("rst_occ", 32'(buffer_occupancy), 32'd0);
    chk("rst_flags", 32'({rx_overflow, rx_underflow}), 32'd0);
    n_rst = 1'b1;

    // Four stores then one 4-byte read
    seq[0] = 8'h3C; seq[1] = 8'hD3; seq[2] = 8'hF0; seq[3] = 8'hE8;
    for (int i = 0; i < 4; i++) cyc(1'b1, seq[i], 1'b0, RD_1B, 1'b0);
    chk("t1_occ4", 32'(buffer_occupancy), 32'd4);
    cyc(1'b0, 8'h00, 1'b1, RD_4B, 1'b0);
    chk("t1_data", rx_data, 32'hE8F0D33C);
    chk("t1_model", m_data, 32'hE8F0D33C);
    chk("t1_occ0", 32'(buffer_occupancy), 32'd0);
    chk("t1_flags", 32'({rx_overflow, rx_underflow}), 32'd0);

    // Underflow on a 2-byte read with one byte held
    cyc(1'b1, 8'hAA, 1'b0, RD_1B, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, RD_2B, 1'b0);
    chk("t2_udf", 32'(rx_underflow), 32'd1);
    chk("t2_occ", 32'(buffer_occupancy), 32'd1);
    chk("t2_hold", rx_data, 32'hE8F0D33C);
    cyc(1'b0, 8'h00, 1'b0, RD_1B, 1'b0);
    chk("t2_udf_end", 32'(rx_underflow), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, RD_1B, 1'b0);
    chk("t2_data", rx_data, 32'h000000AA);

    // Fill, overflow, then store with a freeing read while full
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b0, RD_1B, 1'b0);
    chk("t3_full", 32'(buffer_occupancy), 32'd64);
    cyc(1'b1, 8'h55, 1'b0, RD_1B, 1'b0);
    chk("t3_ovf", 32'(rx_overflow), 32'd1);
    chk("t3_occ", 32'(buffer_occupancy), 32'd64);
    cyc(1'b1, 8'h77, 1'b1, RD_1B, 1'b0);
    chk("t3_rd0", rx_data, 32'h00000000);
    chk("t3_occ_keep", 32'(buffer_occupancy), 32'd64);
    chk("t3_no_ovf", 32'(rx_overflow), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, RD_4B, 1'b0);
    chk("t3_drain1", rx_data, 32'h04030201);
    chk("t3_model", m_data, 32'h04030201);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, RD_4B, 1'b0);
    chk("t3_last", rx_data, 32'h773F3E3D);
    chk("t3_empty", 32'(buffer_occupancy), 32'd0);

    // Wrap test from pointer zero
    cyc(1'b0, 8'h00, 1'b0, RD_1B, 1'b1);
    for (int i = 0; i < 62; i++) cyc(1'b1, 8'(i + 100), 1'b0, RD_1B, 1'b0);
    for (int i = 0; i < 31; i++) cyc(1'b0, 8'h00, 1'b1, RD_2B, 1'b0);
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    for (int i = 0; i < 4; i++) cyc(1'b1, seq[i], 1'b0, RD_1B, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, RD_4B, 1'b0);
    chk("t4_wrap", rx_data, 32'h44332211);
    chk("t4_model", m_data, 32'h44332211);

    // Flush beats same-cycle store and read
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i + 8'hC0), 1'b0, RD_1B, 1'b0);
    chk("t5_occ10", 32'(buffer_occupancy), 32'd10);
    cyc(1'b1, 8'h99, 1'b1, RD_1B, 1'b1);
    chk("t5_occ", 32'(buffer_occupancy), 32'd0);
    chk("t5_data", rx_data, 32'h0);
    chk("t5_flags", 32'({rx_overflow, rx_underflow}), 32'd0);

    // Mixed traffic including simultaneous read/write and the reserved size
    for (int i = 0; i < 24; i++)
      cyc((i % 3) != 0, 8'(i * 7 + 1), (i % 2) == 1, 2'(i % 4), 1'b0);

    // Asynchronous reset in the middle of a write sequence
    cyc(1'b1, 8'hA1, 1'b0, RD_1B, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, RD_1B, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, RD_2B, 1'b0);
    store_rx_packet = 1'b1; rx_packet_data = 8'hA3;
    #3;
    n_rst = 1'b0;
    #1;
    chk("t6_data", rx_data, 32'h0);
    chk("t6_occ", 32'(buffer_occupancy), 32'd0);
    chk("t6_flags", 32'({rx_overflow, rx_underflow}), 32'd0);
    store_rx_packet = 1'b0;
    @(posedge tb_clk); #1;
    n_rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, RD_1B, 1'b0);
    chk("t6_udf", 32'(rx_underflow), 32'd1);
    chk("t6_model_udf", 32'(m_udf), 32'd1);

    repeat (2) @(posedge tb_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/usb_rx_data_buffer.md
Name: usb_rx_data_buffer

Overview:
Receive-side byte FIFO directly downstream of usb_rx. It captures each decoded data byte on store_rx_packet and holds it until the AHB slave drains it in 1-, 2- or 4-byte little-endian reads. It reports occupancy to the AHB-side status logic, and flags overflow and underflow as single-cycle pulses.

Parameters:
DEPTH, 64, number of byte entries; must be a power of 2.
ADDR_W, 6, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock; all logic updates on the rising edge.
n_rst  input  1  asynchronous active-low reset.
store_rx_packet  input  1  write strobe from usb_rx; one byte per cycle while high.
rx_packet_data  input  8  byte from usb_rx; sampled when store_rx_packet=1.
get_rx_data  input  1  read request from the AHB slave.
rx_read_size  input  2  read size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = reserved (treated as 4).
flush  input  1  synchronous clear of all contents.
rx_data  output  32  read data; first-stored byte in [7:0]; unused upper bytes are 0.
buffer_occupancy  output  ADDR_W+1  number of bytes currently held, from 0 to DEPTH.
rx_overflow  output  1  one-cycle pulse when a write is dropped.
rx_underflow  output  1  one-cycle pulse when a read is rejected.

Behaviour:
- Reset (async, n_rst=0):
  - read pointer, write pointer, occupancy = 0.
  - rx_data = 0; rx_overflow = 0; rx_underflow = 0.
  - Storage contents are don't-care.
- Read size: N = 1, 2 or 4, decoded from rx_read_size.
- Read acceptance:
  - A read is accepted when get_rx_data=1 and occupancy >= N. Occupancy is the value registered at the start of the cycle; the same-cycle write is not counted.
  - Accepted read: on the next edge, rx_data is loaded with bytes rd_ptr .. rd_ptr+N-1, with byte k in rx_data[8k+7:8k]. Bytes N..3 are 0. rd_ptr advances by N modulo DEPTH.
  - Latency: the request is in cycle t and rx_data is valid from t+1. rx_data then holds its value until the next accepted read, a flush, or a reset.
- Rejected read: occurs when get_rx_data=1 and occupancy < N.
  - Nothing changes.
  - rx_underflow=1 for exactly the following cycle.
  - rx_data is unchanged.
- Write acceptance:
  - A write is accepted when store_rx_packet=1 and (occupancy < DEPTH, or an accepted read in the same cycle frees at least one byte).
  - The byte is stored at wr_ptr, and wr_ptr advances by 1 modulo DEPTH.
- Dropped write: store_rx_packet=1 and the FIFO is full with no freeing read. The byte is discarded and rx_overflow=1 for the next cycle.
- Simultaneous read and write: both take effect; the new occupancy = occupancy + 1 - N.
- Flush:
  - flush=1 has priority over read and write in the same cycle.
  - Pointers and occupancy go to 0; rx_data goes to 0.
  - No overflow or underflow pulse is generated; a same-cycle store is discarded silently.
- Wrap-around: pointers wrap modulo DEPTH. A multi-byte read that spans the wrap boundary returns bytes in correct order.
- Occupancy is registered: it reflects all writes and reads accepted at the previous edge.
- Reset mid-operation: all state clears immediately; a pending pulse is cancelled.

Decomposition:
- usb_pkg holds:
  - rx_read_size encodings as constants: RD_1B = 0, RD_2B = 1, RD_4B = 2.
  - the rx_packet PID-class encodings shared with usb_rx.
- One sub-module, usb_fifo_ram: DEPTH x 8 register array with one write port and four combinational read taps (addr, addr+1, addr+2, addr+3, modulo DEPTH).
- Pointer, occupancy and flag logic stay in usb_rx_data_buffer.

Test Plan:
- Store 0x3C, 0xD3, 0xF0, 0xE8, then a 4-byte read -> rx_data=0xE8F0D33C one cycle later; occupancy goes 4 -> 0; no flags.
- Store 0xAA, then a 2-byte read -> rx_underflow pulses for 1 cycle; occupancy stays 1; rx_data unchanged. A following 1-byte read -> rx_data=0x000000AA.
- Fill 64 bytes (values 0..63), store 0x55 -> rx_overflow pulses; occupancy=64. Then store plus a 1-byte read in the same cycle -> rx_data=0x00, occupancy stays 64, no overflow.
- Wrap test:
  - Write 62 bytes and read 62 bytes.
  - Write 0x11, 0x22, 0x33, 0x44 (pointer wrap at 64).
  - 4-byte read -> rx_data=0x44332211.
- Flush with store_rx_packet=1 and get_rx_data=1 when occupancy=10 -> occupancy=0, rx_data=0, no overflow or underflow pulses.
- Assert n_rst=0 midway through writing a 4-byte sequence -> all outputs 0 immediately. After release, a 1-byte read -> underflow.
